// File: rtl/xlr8_lfsr_pkg.sv
// Shared register map, bit positions, sequencer states and default tap masks
// for the xlr8_lfsr_mc XB.
package xlr8_lfsr_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_BYTESEL = 3'd2;
    localparam logic [2:0] REG_SEED    = 3'd3;
    localparam logic [2:0] REG_TAP     = 3'd4;
    localparam logic [2:0] REG_DATA    = 3'd5;
    localparam int unsigned NUM_REGS   = 6;

    localparam int unsigned CTRL_RUN       = 0;
    localparam int unsigned CTRL_LONG_HB   = 1;
    localparam int unsigned CTRL_LOAD      = 2;
    localparam int unsigned CTRL_STEPS_LSB = 4;

    localparam int unsigned STATUS_BUSY = 0;
    localparam int unsigned STATUS_ZFIX = 1;
    localparam int unsigned STATUS_OVR  = 2;

    typedef enum logic {StIdle, StBurst} seq_state_e;

    // Maximal-length Galois tap masks.
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [23:0] TAPS_W24 = 24'hE10000;
    localparam logic [31:0] TAPS_W32 = 32'hA3000000;

endpackage

// File: rtl/xlr8_lfsr_mc_core.sv
// Galois LFSR datapath: state and tap registers with load, zero-seed fix-up,
// zero-tap fallback and single-step advance.
module xlr8_lfsr_mc_core #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] DEF_TAPS = '0
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_seed,
    input  logic [WIDTH-1:0] i_taps,
    output logic [WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_taps;
    logic [WIDTH-1:0] w_feedback;

    assign w_feedback = r_state[0] ? r_taps : '0;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= WIDTH'(1);
            r_taps  <= DEF_TAPS;
        end else if (i_load) begin
            // An all-zero state would lock the LFSR up, so it is forced to 1.
            r_state <= (i_seed == '0) ? WIDTH'(1) : i_seed;
            r_taps  <= (i_taps == '0) ? DEF_TAPS : i_taps;
        end else if (i_step) begin
            r_state <= (r_state >> 1) ^ w_feedback;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/xlr8_lfsr_mc.sv
// XLR8 data-memory-bus XB: WIDTH-bit Galois LFSR with staged seed/taps, atomic
// snapshot reads, burst-step sequencer and heartbeat output.
module xlr8_lfsr_mc
    import xlr8_lfsr_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR    = 8'h0,
    parameter int unsigned WIDTH        = 16,
    parameter logic [31:0] DEFAULT_TAPS = 32'h0000_B400,
    parameter int unsigned HB_BITS      = 24
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clken,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       io_out_en,
    input  logic [7:0] ramadr,
    input  logic       ramre,
    input  logic       ramwe,
    input  logic       dm_sel,
    input  logic       hb_enable,
    output logic       heartbeat
);

    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned BSW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
        $error("xlr8_lfsr_mc: WIDTH must be 8, 16, 24 or 32");
    end
    if (HB_BITS < 5) begin : g_bad_hb
        $error("xlr8_lfsr_mc: HB_BITS must be at least 5");
    end

    logic [7:0]         w_off;
    logic               w_hit;
    logic [31:0]        w_bs_idx;
    logic               w_bs_ok;
    logic               w_wr_en;
    logic               w_rd_en;
    logic               w_ctrl_wr;
    logic               w_load;
    logic               w_status_rd;
    logic               w_data_rd0;
    logic               w_busy;
    logic               w_step;
    logic [WIDTH-1:0]   w_state;
    logic [WIDTH-1:0]   w_seed_flat;
    logic [WIDTH-1:0]   w_tap_flat;
    seq_state_e         w_fsm_d;
    logic [3:0]         w_cnt_d;

    logic               r_run;
    logic               r_long_hb;
    logic [3:0]         r_steps;
    logic [BSW-1:0]     r_bytesel;
    logic               r_zfix;
    logic               r_ovr;
    logic [WIDTH-1:0]   r_snap;
    logic [7:0]         r_seed_stage [NBYTES];
    logic [7:0]         r_tap_stage  [NBYTES];
    seq_state_e         r_fsm;
    logic [3:0]         r_cnt;
    logic [HB_BITS-1:0] r_hb_cnt;

    // Offset subtraction wraps in 8 bits, matching BASE_ADDR+k on the bus.
    assign w_off       = ramadr - BASE_ADDR;
    assign w_hit       = dm_sel && (w_off < 8'(NUM_REGS));
    assign io_out_en   = w_hit && ramre;
    assign w_bs_idx    = 32'(r_bytesel);
    assign w_bs_ok     = w_bs_idx < NBYTES;

    assign w_wr_en     = clken && ramwe && w_hit;
    assign w_rd_en     = clken && ramre && w_hit;
    assign w_ctrl_wr   = w_wr_en && (w_off[2:0] == REG_CTRL);
    assign w_load      = w_ctrl_wr && dbus_in[CTRL_LOAD];
    assign w_status_rd = w_rd_en && (w_off[2:0] == REG_STATUS);
    assign w_data_rd0  = w_rd_en && (w_off[2:0] == REG_DATA) && (w_bs_idx == 0);
    assign w_busy      = (r_fsm == StBurst);
    // RUN and a burst never stack: at most one step per edge.
    assign w_step      = clken && (r_run || w_busy);

    always_comb begin
        w_seed_flat = '0;
        w_tap_flat  = '0;
        for (int i = 0; i < NBYTES; i++) begin
            w_seed_flat[8*i +: 8] = r_seed_stage[i];
            w_tap_flat[8*i +: 8]  = r_tap_stage[i];
        end
    end

    xlr8_lfsr_mc_core #(
        .WIDTH    (WIDTH),
        .DEF_TAPS (DEFAULT_TAPS[WIDTH-1:0])
    ) u_core (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_seed  (w_seed_flat),
        .i_taps  (w_tap_flat),
        .o_state (w_state)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_run     <= 1'b0;
            r_long_hb <= 1'b0;
            r_steps   <= '0;
            r_bytesel <= '0;
            r_zfix    <= 1'b0;
            r_ovr     <= 1'b0;
            r_snap    <= '0;
            for (int i = 0; i < NBYTES; i++) begin
                r_seed_stage[i] <= '0;
                r_tap_stage[i]  <= DEFAULT_TAPS[8*i +: 8];
            end
        end else if (clken) begin
            if (w_ctrl_wr) begin
                r_run     <= dbus_in[CTRL_RUN];
                r_long_hb <= dbus_in[CTRL_LONG_HB];
                r_steps   <= dbus_in[CTRL_STEPS_LSB +: 4];
            end
            if (w_wr_en && (w_off[2:0] == REG_BYTESEL)) r_bytesel <= dbus_in[BSW-1:0];
            if (w_wr_en && (w_off[2:0] == REG_SEED) && w_bs_ok) begin
                r_seed_stage[r_bytesel] <= dbus_in;
            end
            if (w_wr_en && (w_off[2:0] == REG_TAP) && w_bs_ok) begin
                r_tap_stage[r_bytesel] <= dbus_in;
            end
            if (w_data_rd0) r_snap <= w_state;
            // Setting an event wins over a same-cycle STATUS read clear.
            if (w_load && (w_seed_flat == '0)) r_zfix <= 1'b1;
            else if (w_status_rd)              r_zfix <= 1'b0;
            if (w_data_rd0 && w_busy)          r_ovr  <= 1'b1;
            else if (w_status_rd)              r_ovr  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fsm <= StIdle;
            r_cnt <= '0;
        end else begin
            r_fsm <= w_fsm_d;
            r_cnt <= w_cnt_d;
        end
    end

    always_comb begin
        w_fsm_d = r_fsm;
        w_cnt_d = r_cnt;
        if (w_load) begin
            w_fsm_d = StIdle;
            w_cnt_d = '0;
        end else if (clken) begin
            unique case (r_fsm)
                StIdle: begin
                    if (w_data_rd0) begin
                        w_fsm_d = StBurst;
                        w_cnt_d = r_steps;
                    end
                end
                StBurst: begin
                    if (r_cnt == '0) w_fsm_d = StIdle;
                    else             w_cnt_d = r_cnt - 4'd1;
                end
                default: w_fsm_d = StIdle;
            endcase
        end
    end

    always_comb begin
        dbus_out = 8'h00;
        if (w_hit) begin
            case (w_off[2:0])
                REG_CTRL:    dbus_out = {r_steps, 2'b00, r_long_hb, r_run};
                REG_STATUS:  dbus_out = {5'd0, r_ovr, r_zfix, w_busy};
                REG_BYTESEL: dbus_out = 8'(r_bytesel);
                REG_SEED:    if (w_bs_ok) dbus_out = r_seed_stage[r_bytesel];
                REG_TAP:     if (w_bs_ok) dbus_out = r_tap_stage[r_bytesel];
                REG_DATA: begin
                    if (w_bs_idx == 0) dbus_out = w_state[7:0];
                    else if (w_bs_ok)  dbus_out = r_snap[8*w_bs_idx +: 8];
                end
                default:     dbus_out = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_hb_cnt <= '0;
        else       r_hb_cnt <= r_hb_cnt + 1'b1;
    end

    assign heartbeat = hb_enable &
                       (r_long_hb ? r_hb_cnt[HB_BITS-1] : r_hb_cnt[HB_BITS-4]);

endmodule

// File: doc/xlr8_lfsr_mc.md
Name: xlr8_lfsr_mc

Overview:
- Parametrised successor XB to the 8-bit LFSR: a Galois LFSR of WIDTH bits (8/16/24/32) with programmable tap mask and multi-byte seed/tap staging.
- Atomic multi-byte snapshot reads and a burst-step sequencer that advances N steps per data read.
- Heartbeat output with short/long period.
- Sits on the XLR8 data-memory bus like other XBs; software reaches it through six consecutive register addresses.

Parameters:
- BASE_ADDR, 8'h0, ramadr of register 0; registers occupy BASE_ADDR+0..+5.
- WIDTH, 16, LFSR width; legal values 8, 16, 24, 32. Any other value is an elaboration error.
- DEFAULT_TAPS, 32'h0000_B400, tap mask loaded at reset; truncated to WIDTH.
- HB_BITS, 24, heartbeat counter width; must be ≥ 5.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- clken  input  1  qualifies all bus writes and read side-effects
- dbus_in  input  8  write data
- dbus_out  output  8  read data
- io_out_en  output  1  high when this XB drives read data
- ramadr  input  8  DM address
- ramre  input  1  read strobe
- ramwe  input  1  write strobe
- dm_sel  input  1  DM space select
- hb_enable  input  1  heartbeat gate
- heartbeat  output  1  heartbeat

Behaviour:
- Decode: reg_sel[k] = dm_sel && ramadr==BASE_ADDR+k. io_out_en = any reg_sel && ramre; combinational. dbus_out = 0 when no register is selected.
- +0 CTRL (R/W, reset 0):
  - b0 RUN: free-run, one step per clken cycle.
  - b1 LONG_HB.
  - b2 LOAD: write-1 pulse, reads 0.
  - b7:4 STEPS: burst length = STEPS+1.
- +1 STATUS (RO): b0 BUSY, b1 ZFIX (sticky), b2 OVR (sticky). Reading STATUS with clken clears ZFIX and OVR at the end of that cycle.
- +2 BYTESEL (R/W, reset 0): byte index; width clog2(WIDTH/8), with a minimum of 1 bit. Unused bits read 0.
- +3 SEED window: a write stores dbus_in into seed_stage[BYTESEL]. A read returns that byte. Reset 0.
- +4 TAP window: the same access rules as SEED, applied to tap_stage. Reset to DEFAULT_TAPS.
- +5 DATA window:
  - BYTESEL==0: the read returns live state[7:0] combinationally. With clken, snap <= state in the same edge.
  - BYTESEL!=0: the read returns snap[8*BYTESEL+:8].
- LOAD: on the edge, state <= seed_stage and taps <= tap_stage.
  - Zero seed: state <= 1 and ZFIX is set.
  - Zero tap mask: taps <= DEFAULT_TAPS.
  - LOAD cancels any burst (BUSY -> 0).
- Step (Galois): state <= (state>>1) ^ (state[0] ? taps : 0).
- Sequencer FSM:
  - IDLE: a DATA read of byte 0 with clken loads cnt=STEPS and goes to BURST.
  - BURST: one step per clken cycle, cnt decrements. After the step with cnt==0 the FSM returns to IDLE.
  - BUSY = (FSM==BURST).
  - Burst latency is STEPS+1 clken cycles, first step on the edge after the read.
  - A byte-0 DATA read while BUSY sets OVR and does not restart the burst.
- RUN=1: steps every clken cycle regardless of FSM. The FSM still runs and still reports BUSY; there are no double steps.
- Priority per edge: reset > LOAD > step. A CTRL write with LOAD=1 also updates the other CTRL bits.
- clken=0: no register update, no step, no counter advance. Reads still drive dbus_out.
- Heartbeat:
  - A free-running HB_BITS counter advances on every clk.
  - heartbeat = hb_enable & (LONG_HB ? cnt[HB_BITS-1] : cnt[HB_BITS-4]).
- Reset values: state=1, taps=DEFAULT_TAPS, snap=0, CTRL=0, STATUS=0, FSM=IDLE, heartbeat=0, dbus_out=0, io_out_en=0.
- Reset mid-burst: everything returns to its reset value immediately (asynchronous).

Decomposition:
- Package xlr8_lfsr_pkg holds:
  - register offsets REG_CTRL..REG_DATA;
  - CTRL/STATUS bit positions;
  - the FSM state enum (IDLE, BURST);
  - maximal-length default tap constants for 8/16/24/32 (8'hB8, 16'hB400, 24'hE10000, 32'hA3000000).
- Sub-module xlr8_lfsr_mc_core holds state and taps: load, zero-fix, Galois step. It is purely datapath plus registers. The bus decode and FSM stay at the top level.

Test Plan:
- Reset, WIDTH=16: read +5 BYTESEL=0 -> 8'h01 with io_out_en=1; STATUS reads 0; heartbeat=0.
- Seed 16'hACE1 via BYTESEL 0/1 plus writes to +3, then CTRL=8'h04:
  - read DATA byte 0 -> 8'hE1;
  - byte 1 -> 8'hAC;
  - after 1 step, state = 16'hE270.
- Seed 0 then LOAD -> state=1, STATUS.ZFIX=1. Reading STATUS returns 8'h02, and a second read returns 8'h00.
- CTRL STEPS=3: a byte-0 DATA read raises BUSY for exactly 4 clken cycles, ending at 4 steps from the snapshot. A byte-0 read during BUSY sets OVR and leaves the burst length unchanged.
- RUN=1 with period-checking over 2^16-1 steps: the state returns to its seed exactly at step 65535 and never before. With clken toggling 50% the count is unchanged.
- Assert rstn low mid-burst -> BUSY=0, state=1, CTRL=0 immediately. hb_enable=1 with LONG_HB=0 and HB_BITS=5: heartbeat period is 4 clk cycles.
